alu_step_sequencer: RTL and testbench

Parametrised control-step sequencer for the simple-cpu datapath. It replaces hand-driven control strobes with a state machine that runs the fetch steps (T0–T2) and the three-operand ALU execute steps (T3–T5/T6) of one R-format instruction. It supports a configurable register-file size, memory wait states and a two-result MUL/DIV path into HI/LO. It can also run back-to-back instructions. It drives the datapath's existing `*in`, `*out` and `operation` controls directly.

---
 rtl/cpu_ctrl_pkg.sv | 51 +++++
 rtl/alu_step_sequencer_if.sv | 35 +++
 rtl/reg_onehot_decoder.sv | 17 +
 rtl/alu_step_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_step_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the simple-cpu control sequencer: step states, opcodes,
// instruction field positions and opcode classification helpers.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  function automatic logic is_two_result(input logic [4:0] opcode);
    return (opcode == OP_MUL) || (opcode == OP_DIV);
  endfunction

  function automatic logic is_legal_op(input logic [4:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL, OP_NEG, OP_NOT, OP_MUL, OP_DIV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_step_sequencer_if.sv
// Control bundle between the step sequencer (master) and the datapath side (slave).
interface alu_step_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OP_WIDTH = 5
);
  import cpu_ctrl_pkg::*;

  // start is a level request, sampled only in IDLE and in the final step;
  // done pulses one cycle in that final step, err pulses one cycle in T3.
  logic                start;
  logic                mem_ready;
  logic [31:0]         instr;
  logic                PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout;
  logic                IRin, Yin, Zlowout, Zhighout, LOin, HIin;
  logic [NUM_REGS-1:0] Rout;
  logic [NUM_REGS-1:0] Rin;
  logic [OP_WIDTH-1:0] operation;
  logic                busy, done, err;
  state_t              dbg_state;

  modport master (
    input  start, mem_ready, instr,
    output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
    output IRin, Yin, Zlowout, Zhighout, LOin, HIin,
    output Rout, Rin, operation, busy, done, err, dbg_state
  );

  modport slave (
    output start, mem_ready, instr,
    input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
    input  IRin, Yin, Zlowout, Zhighout, LOin, HIin,
    input  Rout, Rin, operation, busy, done, err, dbg_state
  );

endinterface

// File: rtl/reg_onehot_decoder.sv
// Register index to one-hot select; indices beyond NUM_REGS decode to all zeros.
module reg_onehot_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == 4'(i));
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Fetch/execute control-step sequencer for one R-format instruction at a time,
// with memory wait states and a two-result MUL/DIV path into HI/LO.
module alu_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_WIDTH = 5
) (
  input logic                  Clock,
  input logic                  clear,
  alu_step_sequencer_if.master bus
);

  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  state_t     state_q, state_d;
  logic [4:0] opc_q, opc_d;
  logic [3:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic       two_res, illegal;
  logic       rout_en, rin_en;
  logic [3:0] rout_sel;
  logic       unused_instr_bits;

  function automatic logic reg_ok(input logic [3:0] idx);
    return {1'b0, idx} < NREGS;
  endfunction

  assign unused_instr_bits = ^bus.instr[RC_LSB-1:0];

  // Ra is only a destination for single-result ops; MUL/DIV write HI/LO instead.
  assign two_res = is_two_result(opc_q);
  assign illegal = !is_legal_op(opc_q) || !reg_ok(rb_q) || !reg_ok(rc_q) ||
                   (!two_res && !reg_ok(ra_q));

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (bus.mem_ready) state_d = S_T2;
      S_T2: begin
        state_d = S_T3;
        opc_d   = bus.instr[OPC_MSB:OPC_LSB];
        ra_d    = bus.instr[RA_MSB:RA_LSB];
        rb_d    = bus.instr[RB_MSB:RB_LSB];
        rc_d    = bus.instr[RC_MSB:RC_LSB];
      end
      S_T3:   state_d = illegal ? S_IDLE : S_T4;
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (two_res)        state_d = S_T6;
        else if (bus.start) state_d = S_T0;
        else                state_d = S_IDLE;
      end
      S_T6:   state_d = bus.start ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
    end
  end

  // Strobes are forced low while clear is high so an abort never leaks a write.
  always_comb begin
    bus.PCout     = 1'b0;
    bus.MARin     = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Zin       = 1'b0;
    bus.PCin      = 1'b0;
    bus.Read      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.LOin      = 1'b0;
    bus.HIin      = 1'b0;
    bus.operation = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    rout_en       = 1'b0;
    rin_en        = 1'b0;
    if (!clear) begin
      bus.busy = (state_q != S_IDLE);
      case (state_q)
        S_T0: begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
          bus.Zin   = 1'b1;
        end
        S_T1: begin
          bus.Zlowout = 1'b1;
          bus.Read    = 1'b1;
          bus.MDRin   = 1'b1;
          bus.PCin    = bus.mem_ready;
        end
        S_T2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
        end
        S_T3: begin
          bus.err = illegal;
          bus.Yin = !illegal;
          rout_en = !illegal;
        end
        S_T4: begin
          rout_en       = 1'b1;
          bus.Zin       = 1'b1;
          bus.operation = OP_WIDTH'(opc_q);
        end
        S_T5: begin
          bus.Zlowout = 1'b1;
          bus.LOin    = two_res;
          rin_en      = !two_res;
          bus.done    = !two_res;
        end
        S_T6: begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
          bus.done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rout_sel      = (state_q == S_T3) ? rb_q : rc_q;
  assign bus.dbg_state = state_q;

  reg_onehot_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .idx    (rout_sel),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

  reg_onehot_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .idx    (ra_q),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer: 16- and 8-register instances run in lockstep
// against a per-instruction step-plan model, plus directed literal checks.
module tb_alu_step_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int C_T0 = 0, C_T1 = 1, C_T2 = 2, C_T3 = 3, C_ERR = 4;
  localparam int C_T4 = 5, C_T5 = 6, C_T5M = 7, C_T6 = 8;

  logic        Clock;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] instr;

  int tests_run;
  int tests_failed;
  int cyc;

  // ---------------- clock / DUTs ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  alu_step_sequencer_if #(.NUM_REGS(16), .OP_WIDTH(5)) b16 ();
  alu_step_sequencer_if #(.NUM_REGS(8),  .OP_WIDTH(5)) b8 ();

  assign b16.start     = start;
  assign b16.mem_ready = mem_ready;
  assign b16.instr     = instr;
  assign b8.start      = start;
  assign b8.mem_ready  = mem_ready;
  assign b8.instr      = instr;

  alu_step_sequencer #(.NUM_REGS(16), .OP_WIDTH(5)) dut16 (
    .Clock (Clock),
    .clear (clear),
    .bus   (b16.master)
  );

  alu_step_sequencer #(.NUM_REGS(8), .OP_WIDTH(5)) dut8 (
    .Clock (Clock),
    .clear (clear),
    .bus   (b8.master)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- model: list of steps for the instruction in flight ----------------
  int         plan [2][8];
  int         plan_len [2];
  int         plan_pos [2];
  bit         active [2];
  logic [4:0] m_opc [2];
  logic [3:0] m_ra [2];
  logic [3:0] m_rb [2];
  logic [3:0] m_rc [2];

  function automatic bit model_legal(input logic [4:0] opc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc, input int nregs);
    bit two;
    bit single;
    two    = (opc == 5'd15) || (opc == 5'd16);
    single = (opc >= 5'd3) && (opc <= 5'd13);
    if (!(two || single)) return 1'b0;
    if (int'(rb) >= nregs || int'(rc) >= nregs) return 1'b0;
    if (single && int'(ra) >= nregs) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_plan(input int d);
    plan[d][0]  = C_T0;
    plan[d][1]  = C_T1;
    plan[d][2]  = C_T2;
    plan_len[d] = 3;
    plan_pos[d] = 0;
    active[d]   = 1'b1;
  endtask

  // Applies the inputs present at the coming rising edge to the model.
  task automatic model_advance(input int d, input int nregs);
    int code;
    if (clear) begin
      active[d] = 1'b0;
      return;
    end
    if (!active[d]) begin
      if (start) start_plan(d);
      return;
    end
    code = plan[d][plan_pos[d]];
    if (code == C_T1 && !mem_ready) return;
    if (code == C_T2) begin
      m_opc[d] = instr[31:27];
      m_ra[d]  = instr[26:23];
      m_rb[d]  = instr[22:19];
      m_rc[d]  = instr[18:15];
      if (!model_legal(m_opc[d], m_ra[d], m_rb[d], m_rc[d], nregs)) begin
        plan[d][3] = C_ERR;
        plan_len[d] = 4;
      end else if (m_opc[d] == 5'd15 || m_opc[d] == 5'd16) begin
        plan[d][3] = C_T3; plan[d][4] = C_T4; plan[d][5] = C_T5M; plan[d][6] = C_T6;
        plan_len[d] = 7;
      end else begin
        plan[d][3] = C_T3; plan[d][4] = C_T4; plan[d][5] = C_T5;
        plan_len[d] = 6;
      end
    end
    plan_pos[d]++;
    if (plan_pos[d] == plan_len[d]) begin
      if (start && (code == C_T5 || code == C_T6)) start_plan(d);
      else active[d] = 1'b0;
    end
  endtask

  function automatic void model_expect(input int d, output logic [16:0] st, output logic [15:0] ro,
                                       output logic [15:0] ri, output logic [4:0] op);
    logic pcout, marin, incpc, zin, pcin, rd, mdrin, mdrout, irin, yin;
    logic zlo, zhi, loin, hiin, bsy, dn, er;
    int   code;
    {pcout, marin, incpc, zin, pcin, rd, mdrin, mdrout, irin, yin} = '0;
    {zlo, zhi, loin, hiin, bsy, dn, er} = '0;
    ro = '0;
    ri = '0;
    op = '0;
    if (!clear && active[d]) begin
      code = plan[d][plan_pos[d]];
      bsy  = 1'b1;
      case (code)
        C_T0:  begin pcout = 1'b1; marin = 1'b1; incpc = 1'b1; zin = 1'b1; end
        C_T1:  begin zlo = 1'b1; rd = 1'b1; mdrin = 1'b1; pcin = mem_ready; end
        C_T2:  begin mdrout = 1'b1; irin = 1'b1; end
        C_T3:  begin ro = 16'(1) << m_rb[d]; yin = 1'b1; end
        C_ERR: er = 1'b1;
        C_T4:  begin ro = 16'(1) << m_rc[d]; zin = 1'b1; op = m_opc[d]; end
        C_T5:  begin zlo = 1'b1; ri = 16'(1) << m_ra[d]; dn = 1'b1; end
        C_T5M: begin zlo = 1'b1; loin = 1'b1; end
        C_T6:  begin zhi = 1'b1; hiin = 1'b1; dn = 1'b1; end
        default: ;
      endcase
    end
    st = {pcout, marin, incpc, zin, pcin, rd, mdrin, mdrout, irin, yin,
          zlo, zhi, loin, hiin, bsy, dn, er};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge Clock) begin
    logic [16:0] e_st, a_st;
    logic [15:0] e_ro, e_ri, a_ro, a_ri;
    logic [4:0]  e_op, a_op;
    for (int d = 0; d < 2; d++) begin
      model_expect(d, e_st, e_ro, e_ri, e_op);
      if (d == 0) begin
        a_st = {b16.PCout, b16.MARin, b16.IncPC, b16.Zin, b16.PCin, b16.Read, b16.MDRin,
                b16.MDRout, b16.IRin, b16.Yin, b16.Zlowout, b16.Zhighout, b16.LOin, b16.HIin,
                b16.busy, b16.done, b16.err};
        a_ro = b16.Rout;
        a_ri = b16.Rin;
        a_op = b16.operation;
      end else begin
        a_st = {b8.PCout, b8.MARin, b8.IncPC, b8.Zin, b8.PCin, b8.Read, b8.MDRin,
                b8.MDRout, b8.IRin, b8.Yin, b8.Zlowout, b8.Zhighout, b8.LOin, b8.HIin,
                b8.busy, b8.done, b8.err};
        a_ro = {8'h00, b8.Rout};
        a_ri = {8'h00, b8.Rin};
        a_op = b8.operation;
      end
      check($sformatf("cyc%0d_d%0d_strobes", cyc, d), 32'(a_st), 32'(e_st));
      check($sformatf("cyc%0d_d%0d_rout_rin", cyc, d), {a_ro, a_ri}, {e_ro, e_ri});
      check($sformatf("cyc%0d_d%0d_operation", cyc, d), 32'(a_op), 32'(e_op));
      model_advance(d, (d == 0) ? 16 : 8);
    end
  end

  // ---------------- directed driver and observations ----------------
  int          done_k [2], done2_k [2], done_cnt [2], err_k [2], lo_k [2], hi_k [2];
  int          rd_cnt [2], pcin_cnt [2], rin_cnt [2], busy_cnt [2], yin_cnt [2];
  logic [15:0] rout_k [20];
  logic [15:0] rin_k [20];
  logic [4:0]  op_k [20];
  logic        nz_k [20];

  task automatic sample(input int d, input int k, input logic dn, input logic er, input logic rd,
                        input logic pc, input logic rin_nz, input logic lo, input logic hi,
                        input logic bsy, input logic yin);
    if (dn) begin
      if (done_cnt[d] == 0) done_k[d] = k;
      else if (done_cnt[d] == 1) done2_k[d] = k;
      done_cnt[d]++;
    end
    if (er && err_k[d] == 0) err_k[d] = k;
    if (lo && lo_k[d] == 0) lo_k[d] = k;
    if (hi && hi_k[d] == 0) hi_k[d] = k;
    if (rd) rd_cnt[d]++;
    if (pc) pcin_cnt[d]++;
    if (rin_nz) rin_cnt[d]++;
    if (bsy) busy_cnt[d]++;
    if (yin) yin_cnt[d]++;
  endtask

  // Cycle k=1 is the first cycle after the edge that samples start.
  task automatic run_instr(input logic [31:0] ins, input int mr_low, input int start_until,
                           input int clear_at, input int max_k);
    for (int d = 0; d < 2; d++) begin
      done_k[d] = 0; done2_k[d] = 0; done_cnt[d] = 0; err_k[d] = 0; lo_k[d] = 0; hi_k[d] = 0;
      rd_cnt[d] = 0; pcin_cnt[d] = 0; rin_cnt[d] = 0; busy_cnt[d] = 0; yin_cnt[d] = 0;
    end
    for (int k = 0; k < 20; k++) begin
      rout_k[k] = '0; rin_k[k] = '0; op_k[k] = '0; nz_k[k] = 1'b0;
    end
    instr = ins;
    start = 1'b1;
    for (int k = 1; k <= max_k; k++) begin
      @(posedge Clock);
      #1;
      start     = (k < start_until);
      clear     = (k == clear_at);
      mem_ready = !(k >= 2 && k < 2 + mr_low);
      #1;
      sample(0, k, b16.done, b16.err, b16.Read, b16.PCin, |b16.Rin, b16.LOin, b16.HIin,
             b16.busy, b16.Yin);
      sample(1, k, b8.done, b8.err, b8.Read, b8.PCin, |b8.Rin, b8.LOin, b8.HIin,
             b8.busy, b8.Yin);
      rout_k[k] = b16.Rout;
      rin_k[k]  = b16.Rin;
      op_k[k]   = b16.operation;
      nz_k[k]   = |{b16.PCout, b16.MARin, b16.IncPC, b16.Zin, b16.PCin, b16.Read, b16.MDRin,
                    b16.MDRout, b16.IRin, b16.Yin, b16.Zlowout, b16.Zhighout, b16.LOin,
                    b16.HIin, b16.busy, b16.done, b16.err, b16.Rout, b16.Rin, b16.operation};
    end
    start     = 1'b0;
    clear     = 1'b0;
    mem_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    clear        = 1'b1;
    start        = 1'b0;
    mem_ready    = 1'b1;
    instr        = 32'h0;

    // Reset, with start asserted under clear
    repeat (2) @(posedge Clock);
    #1 start = 1'b1;
    @(posedge Clock);
    #2;
    check("reset_busy", 32'(b16.busy), 32'd0);
    check("reset_rout_rin", {b16.Rout, b16.Rin}, 32'd0);
    check("reset_state", 32'(b16.dbg_state), 32'(S_IDLE));
    start = 1'b0;
    clear = 1'b0;
    @(posedge Clock);
    #2;

    // AND R4,R3,R7
    run_instr(32'h2A1B8000, 0, 1, 0, 10);
    check("and_t3_rout", 32'(rout_k[4]), 32'h0008);
    check("and_t4_rout", 32'(rout_k[5]), 32'h0080);
    check("and_t4_op", 32'(op_k[5]), 32'h05);
    check("and_t5_rin", 32'(rin_k[6]), 32'h0010);
    check("and_latency16", done_k[0], 6);
    check("and_latency8", done_k[1], 6);
    check("and_done_count", done_cnt[0], 1);
    check("and_busy_cycles", busy_cnt[0], 6);

    // ROR R4,R3,R7 with three wait states in T1
    run_instr(32'h3A1B8000, 3, 1, 0, 14);
    check("ror_t1_cycles", rd_cnt[0], 4);
    check("ror_pcin_cycles", pcin_cnt[0], 1);
    check("ror_t4_op", 32'(op_k[8]), 32'h07);
    check("ror_latency", done_k[0], 9);

    // MUL R3,R7
    run_instr(32'h781B8000, 0, 1, 0, 10);
    check("mul_lo_cycle", lo_k[0], 6);
    check("mul_hi_cycle", hi_k[0], 7);
    check("mul_latency", done_k[0], 7);
    check("mul_rin_cycles", rin_cnt[0], 0);
    check("mul_busy_cycles", busy_cnt[0], 7);

    // Illegal opcode
    run_instr(32'hF8000000, 0, 1, 0, 8);
    check("illop_err16", err_k[0], 4);
    check("illop_err8", err_k[1], 4);
    check("illop_done", done_cnt[0], 0);
    check("illop_rout", 32'(rout_k[4]), 32'h0);
    check("illop_yin", yin_cnt[0], 0);
    check("illop_busy_cycles", busy_cnt[0], 4);

    // Rc=9: legal with 16 registers, illegal with 8
    run_instr(32'h2A1C8000, 0, 1, 0, 10);
    check("rc9_err8", err_k[1], 4);
    check("rc9_done8", done_cnt[1], 0);
    check("rc9_latency16", done_k[0], 6);
    check("rc9_t4_rout16", 32'(rout_k[5]), 32'h0200);
    check("rc9_err16", err_k[0], 0);

    // Back-to-back AND, start held through the first final step
    run_instr(32'h2A1B8000, 0, 7, 0, 16);
    check("b2b_done1", done_k[0], 6);
    check("b2b_done2", done2_k[0], 12);
    check("b2b_done_count", done_cnt[0], 2);
    check("b2b_busy_cycles", busy_cnt[0], 12);

    // clear during T4
    run_instr(32'h2A1B8000, 0, 1, 5, 10);
    check("clr_outputs_after", 32'(nz_k[6]), 32'd0);
    check("clr_done", done_cnt[0], 0);
    check("clr_rin", rin_cnt[0], 0);
    check("clr_busy_cycles", busy_cnt[0], 4);
    run_instr(32'h2A1B8000, 0, 1, 0, 10);
    check("clr_rerun_latency", done_k[0], 6);
    check("clr_rerun_rin", 32'(rin_k[6]), 32'h0010);

    // start together with clear from IDLE
    start = 1'b1;
    clear = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    clear = 1'b0;
    #1;
    check("startclr_busy", 32'(b16.busy), 32'd0);
    check("startclr_state", 32'(b16.dbg_state), 32'(S_IDLE));
    @(posedge Clock);
    #2;
    check("startclr_busy_next", 32'(b16.busy), 32'd0);

    repeat (2) @(posedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
